aes128_stream_ctrl: RTL and testbench

AES128_STREAM_CTRL -- requirements
Module: aes128_stream_ctrl

---
 rtl/aes128_pkg.sv | 31 +++
 rtl/aes128_byte_serializer.sv | 55 +++++
 rtl/aes128_stream_ctrl.sv | 140 ++++++++++++++
 tb/tb_aes128_stream_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_pkg.sv
// Shared types and constants for the AES-128 byte-stream controller and its
// output serializer.
package aes128_pkg;

    localparam int BLOCK_BYTES    = 16;
    localparam int TIMEOUT_CYCLES = 32;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_ISSUE,
        ST_SETTLE,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        CMD_ENC  = 2'b00,
        CMD_DEC  = 2'b01,
        CMD_KEY  = 2'b10,
        CMD_RSVD = 2'b11
    } cmd_t;

    // The reserved encoding behaves exactly like encrypt.
    function automatic cmd_t normalize_cmd(input logic [1:0] raw);
        cmd_t c;
        c = cmd_t'(raw);
        if (c == CMD_RSVD) c = CMD_ENC;
        return c;
    endfunction

endpackage

// File: rtl/aes128_byte_serializer.sv
// Captures a 128-bit core result and presents it as 16 bytes, MSB first,
// on a valid/ready stream.
module aes128_byte_serializer
    import aes128_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         capture,
    input  logic [127:0] block,
    input  logic         ready,
    output logic [7:0]   data,
    output logic         valid,
    output logic         done
);

    localparam logic [3:0] LAST_BYTE = 4'(BLOCK_BYTES - 1);

    logic [127:0] shreg;
    logic [3:0]   idx;
    logic         prime;

    // A capture is followed by one priming cycle that moves byte 0 into the
    // output register; the data byte only advances on a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            idx   <= '0;
            prime <= 1'b0;
            data  <= '0;
            valid <= 1'b0;
        end else begin
            prime <= 1'b0;
            if (capture) begin
                shreg <= block;
                prime <= 1'b1;
            end else if (prime) begin
                data  <= shreg[127:120];
                shreg <= {shreg[119:0], 8'h00};
                idx   <= '0;
                valid <= 1'b1;
            end else if (valid && ready) begin
                idx <= idx + 4'd1;
                if (idx == LAST_BYTE) begin
                    valid <= 1'b0;
                end else begin
                    data  <= shreg[127:120];
                    shreg <= {shreg[119:0], 8'h00};
                end
            end
        end
    end

    assign done = valid && ready && (idx == LAST_BYTE);

endmodule

// File: rtl/aes128_stream_ctrl.sv
// Byte-stream front end for an iterative AES-128 core: collects 16-byte
// blocks, drives the core handshake and streams the result back out.
module aes128_stream_ctrl
    import aes128_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [7:0]   s_data_i,
    input  logic         s_valid_i,
    input  logic [1:0]   s_cmd_i,
    output logic         s_ready_o,
    output logic [7:0]   m_data_o,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic [127:0] aes_block_o,
    output logic         aes_reset_key_o,
    output logic         aes_load_data_o,
    output logic         aes_enc_or_dec_o,
    input  logic [127:0] aes_cipher_text_i,
    input  logic         aes_cipher_ready_i,
    input  logic         aes_key_ready_i,
    output logic         key_valid_o,
    output logic         err_nokey_o,
    output logic         err_timeout_o
);

    localparam logic [3:0] LAST_BYTE = 4'(BLOCK_BYTES - 1);
    localparam logic [4:0] LAST_WAIT = 5'(TIMEOUT_CYCLES - 1);

    state_t       state;
    cmd_t         cmd;
    cmd_t         cmd_in;
    logic [3:0]   cnt;
    logic [4:0]   timer;
    logic [127:0] block;
    logic         enc_or_dec;
    logic         key_valid;
    logic         reset_key;
    logic         load_data;
    logic         err_nokey;
    logic         err_timeout;
    logic         accept;
    logic         capture;
    logic         core_ready;
    logic         ser_done;

    assign cmd_in     = normalize_cmd(s_cmd_i);
    assign s_ready_o  = (state == ST_COLLECT) && !rst_i;
    assign accept     = s_valid_i && s_ready_o;
    assign core_ready = (cmd == CMD_KEY) ? aes_key_ready_i : aes_cipher_ready_i;
    assign capture    = (state == ST_WAIT) && (cmd != CMD_KEY) && aes_cipher_ready_i;

    // The timer counts cycles since the core pulse, so the timeout pulse
    // lands exactly TIMEOUT_CYCLES after it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_COLLECT;
            cmd         <= CMD_ENC;
            cnt         <= '0;
            timer       <= '0;
            block       <= '0;
            enc_or_dec  <= 1'b1;
            key_valid   <= 1'b0;
            reset_key   <= 1'b0;
            load_data   <= 1'b0;
            err_nokey   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            reset_key   <= 1'b0;
            load_data   <= 1'b0;
            err_nokey   <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                ST_COLLECT: begin
                    if (accept) begin
                        block[{~cnt, 3'b000} +: 8] <= s_data_i;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd0) begin
                            cmd <= cmd_in;
                            if (cmd_in != CMD_KEY) enc_or_dec <= (cmd_in != CMD_DEC);
                        end
                        if (cnt == LAST_BYTE) begin
                            state <= ST_ISSUE;
                            if (cmd == CMD_KEY)  reset_key <= 1'b1;
                            else if (key_valid)  load_data <= 1'b1;
                            else                 err_nokey <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    timer <= 5'd1;
                    state <= err_nokey ? ST_COLLECT : ST_SETTLE;
                end
                ST_SETTLE: begin
                    timer <= timer + 5'd1;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    timer <= timer + 5'd1;
                    if (core_ready) begin
                        if (cmd == CMD_KEY) begin
                            key_valid <= 1'b1;
                            state     <= ST_COLLECT;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (timer == LAST_WAIT) begin
                        err_timeout <= 1'b1;
                        if (cmd == CMD_KEY) key_valid <= 1'b0;
                        state <= ST_COLLECT;
                    end
                end
                ST_DRAIN: begin
                    if (ser_done) state <= ST_COLLECT;
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

    aes128_byte_serializer u_serializer (
        .clk     (clk_i),
        .rst     (rst_i),
        .capture (capture),
        .block   (aes_cipher_text_i),
        .ready   (m_ready_i),
        .data    (m_data_o),
        .valid   (m_valid_o),
        .done    (ser_done)
    );

    assign aes_block_o      = block;
    assign aes_reset_key_o  = reset_key;
    assign aes_load_data_o  = load_data;
    assign aes_enc_or_dec_o = enc_or_dec;
    assign key_valid_o      = key_valid;
    assign err_nokey_o      = err_nokey;
    assign err_timeout_o    = err_timeout;

endmodule

// File: tb/tb_aes128_stream_ctrl.sv
// Scoreboard bench for aes128_stream_ctrl with a behavioural AES core stub
// that answers the known key/plaintext/ciphertext vectors.
module tb_aes128_stream_ctrl;
    import aes128_pkg::*;

    localparam logic [127:0] KEY = 128'h2B28AB09_7EAEF7CF_15D2154F_16A6883C;
    localparam logic [127:0] PT  = 128'h4C6D7364_6F20756F_72696D6C_6570206F;
    localparam logic [127:0] CT  = 128'hBFC4C771_D72CD65B_5C4DFAAE_FFF80EDB;
    localparam int KEY_LAT    = 8;
    localparam int CIPHER_LAT = 11;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [7:0]   s_data_i = '0;
    logic         s_valid_i = 1'b0;
    logic [1:0]   s_cmd_i = '0;
    logic         s_ready_o;
    logic [7:0]   m_data_o;
    logic         m_valid_o;
    logic         m_ready_i = 1'b1;
    logic [127:0] aes_block_o;
    logic         aes_reset_key_o, aes_load_data_o, aes_enc_or_dec_o;
    logic [127:0] aes_cipher_text_i;
    logic         aes_cipher_ready_i = 1'b0;
    logic         aes_key_ready_i = 1'b0;
    logic         key_valid_o, err_nokey_o, err_timeout_o;

    always #5 clk_i = ~clk_i;

    aes128_stream_ctrl dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .s_data_i           (s_data_i),
        .s_valid_i          (s_valid_i),
        .s_cmd_i            (s_cmd_i),
        .s_ready_o          (s_ready_o),
        .m_data_o           (m_data_o),
        .m_valid_o          (m_valid_o),
        .m_ready_i          (m_ready_i),
        .aes_block_o        (aes_block_o),
        .aes_reset_key_o    (aes_reset_key_o),
        .aes_load_data_o    (aes_load_data_o),
        .aes_enc_or_dec_o   (aes_enc_or_dec_o),
        .aes_cipher_text_i  (aes_cipher_text_i),
        .aes_cipher_ready_i (aes_cipher_ready_i),
        .aes_key_ready_i    (aes_key_ready_i),
        .key_valid_o        (key_valid_o),
        .err_nokey_o        (err_nokey_o),
        .err_timeout_o      (err_timeout_o)
    );

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Core stub: answers only the known vectors, a dead stub never responds.
    logic [127:0] stub_key = '0, stub_block = '0;
    logic         stub_enc = 1'b1;
    logic         stub_dead = 1'b0;
    int           key_lat_cnt = 0, data_lat_cnt = 0;

    assign aes_cipher_text_i = (stub_key == KEY && stub_enc && stub_block == PT)  ? CT :
                               (stub_key == KEY && !stub_enc && stub_block == CT) ? PT : ~stub_block;

    always @(posedge clk_i) begin
        aes_key_ready_i    <= 1'b0;
        aes_cipher_ready_i <= 1'b0;
        if (key_lat_cnt == 1)  aes_key_ready_i <= 1'b1;
        if (data_lat_cnt == 1) aes_cipher_ready_i <= 1'b1;
        if (key_lat_cnt > 0)   key_lat_cnt <= key_lat_cnt - 1;
        if (data_lat_cnt > 0)  data_lat_cnt <= data_lat_cnt - 1;
        if (aes_reset_key_o) begin
            stub_key <= aes_block_o;
            if (!stub_dead) key_lat_cnt <= KEY_LAT - 1;
        end
        if (aes_load_data_o) begin
            stub_block <= aes_block_o;
            stub_enc   <= aes_enc_or_dec_o;
            if (!stub_dead) data_lat_cnt <= CIPHER_LAT - 1;
        end
    end

    int compared = 0, mismatched = 0;
    logic [7:0] exp_q[$];

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake, checks held
    // bytes during back-pressure and timestamps every core/error pulse.
    int n_reset_key = 0, n_load = 0, n_nokey = 0, n_timeout = 0, n_out = 0, width_errs = 0;
    int reset_key_cycle = 0, load_cycle = 0, timeout_cycle = 0, first_valid_cycle = 0;
    logic prev_rk = 0, prev_ld = 0, prev_nk = 0, prev_to = 0, prev_mv = 0;

    always @(negedge clk_i) begin
        if (aes_reset_key_o) begin n_reset_key++; reset_key_cycle = cyc; end
        if (aes_load_data_o) begin n_load++; load_cycle = cyc; end
        if (err_nokey_o) n_nokey++;
        if (err_timeout_o) begin n_timeout++; timeout_cycle = cyc; end
        if ((aes_reset_key_o && prev_rk) || (aes_load_data_o && prev_ld) ||
            (err_nokey_o && prev_nk) || (err_timeout_o && prev_to)) width_errs++;
        if (m_valid_o && !prev_mv) first_valid_cycle = cyc;
        if (m_valid_o) begin
            if (exp_q.size() == 0) begin
                if (m_ready_i) begin
                    n_out++;
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_byte: actual=%0h required=none", m_data_o);
                end
            end else if (m_ready_i) begin
                n_out++;
                checkOutput("out_byte", m_data_o, exp_q.pop_front());
            end else begin
                checkOutput("stall_hold", m_data_o, exp_q[0]);
            end
        end
        prev_rk = aes_reset_key_o;
        prev_ld = aes_load_data_o;
        prev_nk = err_nokey_o;
        prev_to = err_timeout_o;
        prev_mv = m_valid_o;
    end

    int accept_cycle = 0;

    // Sends nbytes of blk MSB-first; cmd rides on byte 0, later_cmd on the rest.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [127:0] blk, input int nbytes,
                                 input logic [1:0] later_cmd, input bit expect_out,
                                 input logic [127:0] expect_blk);
        int guard;
        if (expect_out)
            for (int k = 0; k < 16; k++) exp_q.push_back(expect_blk[127 - 8*k -: 8]);
        for (int i = 0; i < nbytes; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = blk[127 - 8*i -: 8];
            s_cmd_i   = (i == 0) ? cmd : later_cmd;
            guard = 0;
            while (!s_ready_o && guard < 100) begin
                @(negedge clk_i);
                guard++;
            end
            if (!s_ready_o) begin
                checkOutput("s_ready_wait", s_ready_o, 1);
                break;
            end
            accept_cycle = cyc;
            @(negedge clk_i);
        end
        s_valid_i = 1'b0;
    endtask

    task automatic waitDrain(input int limit);
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < limit) begin
            @(negedge clk_i);
            g++;
        end
        checkOutput("drain_left", exp_q.size(), 0);
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    int base_a, base_b, base_out, g;

    initial begin
        repeat (3) @(negedge clk_i);
        checkOutput("rst_s_ready", s_ready_o, 0);
        checkOutput("rst_m_valid", m_valid_o, 0);
        checkOutput("rst_key_valid", key_valid_o, 0);
        checkOutput("rst_enc_or_dec", aes_enc_or_dec_o, 1);
        checkOutput("rst_block", aes_block_o, 0);
        checkOutput("rst_pulses", {aes_reset_key_o, aes_load_data_o, err_nokey_o, err_timeout_o}, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("idle_s_ready", s_ready_o, 1);

        // Data command with no key loaded
        base_a = n_load; base_b = n_nokey; base_out = n_out;
        applyStimulus(CMD_ENC, PT, 16, 2'b00, 0, '0);
        g = 0;
        while (!err_nokey_o && g < 10) begin @(negedge clk_i); g++; end
        checkOutput("nokey_pulse", err_nokey_o, 1);
        @(negedge clk_i);
        checkOutput("nokey_ready_next", s_ready_o, 1);
        checkOutput("nokey_pulse_end", err_nokey_o, 0);
        repeat (20) @(negedge clk_i);
        checkOutput("nokey_count", n_nokey - base_b, 1);
        checkOutput("nokey_no_load", n_load - base_a, 0);
        checkOutput("nokey_no_out", n_out - base_out, 0);

        // Key load
        base_a = n_reset_key; base_out = n_out;
        applyStimulus(CMD_KEY, KEY, 16, 2'b01, 0, '0);
        g = 0;
        while (!key_valid_o && g < 30) begin @(negedge clk_i); g++; end
        checkOutput("key_valid", key_valid_o, 1);
        checkOutput("key_within_13", (cyc - reset_key_cycle) <= 13, 1);
        checkOutput("key_pulses", n_reset_key - base_a, 1);
        checkOutput("key_block", aes_block_o, KEY);
        repeat (10) @(negedge clk_i);
        checkOutput("key_no_out", n_out - base_out, 0);

        // Encrypt, also latency from last input byte to first output byte
        base_out = n_out;
        applyStimulus(CMD_ENC, PT, 16, 2'b00, 1, CT);
        waitDrain(100);
        checkOutput("enc_latency", first_valid_cycle - accept_cycle, 14);
        checkOutput("enc_mode_at_load", stub_enc, 1);
        checkOutput("enc_block_at_load", stub_block, PT);
        checkOutput("enc_held_block", aes_block_o, PT);
        checkOutput("enc_bytes", n_out - base_out, 16);

        // Decrypt with a 5-cycle back-pressure stall mid-drain
        base_out = n_out;
        applyStimulus(CMD_DEC, CT, 16, 2'b00, 1, PT);
        g = 0;
        while (n_out - base_out < 6 && g < 100) begin @(negedge clk_i); g++; end
        @(posedge clk_i);
        #2 m_ready_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #2 m_ready_i = 1'b1;
        waitDrain(100);
        checkOutput("dec_mode_at_load", stub_enc, 0);
        checkOutput("dec_bytes", n_out - base_out, 16);
        checkOutput("dec_mode_held", aes_enc_or_dec_o, 0);

        // Reserved command on byte 0 behaves as encrypt; later cmds ignored
        base_out = n_out;
        applyStimulus(2'b11, PT, 16, 2'b10, 1, CT);
        waitDrain(100);
        checkOutput("rsvd_mode", aes_enc_or_dec_o, 1);
        checkOutput("rsvd_bytes", n_out - base_out, 16);

        // Dead core: data then key command time out
        stub_dead = 1'b1;
        base_a = n_timeout; base_out = n_out;
        applyStimulus(CMD_ENC, PT, 16, 2'b00, 0, '0);
        g = 0;
        while (n_timeout == base_a && g < 60) begin @(negedge clk_i); g++; end
        checkOutput("to_data_count", n_timeout - base_a, 1);
        checkOutput("to_data_delay", timeout_cycle - load_cycle, 32);
        checkOutput("to_data_key_kept", key_valid_o, 1);
        @(negedge clk_i);
        checkOutput("to_data_ready", s_ready_o, 1);
        base_a = n_timeout;
        applyStimulus(CMD_KEY, KEY, 16, 2'b00, 0, '0);
        g = 0;
        while (n_timeout == base_a && g < 60) begin @(negedge clk_i); g++; end
        @(negedge clk_i);
        checkOutput("to_key_delay", timeout_cycle - reset_key_cycle, 32);
        checkOutput("to_key_cleared", key_valid_o, 0);
        checkOutput("to_no_out", n_out - base_out, 0);
        stub_dead = 1'b0;
        repeat (5) @(negedge clk_i);

        // Reset at byte 7 discards the partial block without any pulse
        base_a = n_reset_key + n_load + n_nokey + n_timeout;
        applyStimulus(CMD_KEY, KEY, 7, 2'b00, 0, '0);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checkOutput("midblk_rst_block", aes_block_o, 0);
        rst_i = 1'b0;
        repeat (40) @(negedge clk_i);
        checkOutput("midblk_no_pulse", n_reset_key + n_load + n_nokey + n_timeout - base_a, 0);
        applyStimulus(CMD_KEY, KEY, 16, 2'b00, 0, '0);
        repeat (15) @(negedge clk_i);
        checkOutput("midblk_key_valid", key_valid_o, 1);
        checkOutput("midblk_key_block", aes_block_o, KEY);
        applyStimulus(CMD_ENC, PT, 16, 2'b00, 1, CT);
        waitDrain(100);

        // Reset mid-drain stops the output stream
        base_out = n_out;
        applyStimulus(CMD_ENC, PT, 16, 2'b00, 1, CT);
        g = 0;
        while (n_out - base_out < 4 && g < 100) begin @(negedge clk_i); g++; end
        rst_i = 1'b1;
        @(negedge clk_i);
        exp_q.delete();
        base_out = n_out;
        checkOutput("drain_rst_valid", m_valid_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (40) @(negedge clk_i);
        checkOutput("drain_rst_no_bytes", n_out - base_out, 0);
        checkOutput("drain_rst_key", key_valid_o, 0);

        checkOutput("pulse_width", width_errs, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
